// File: rtl/usb_tx_packet_buffer.sv
// Packet-granular byte FIFO between a packet producer and usb_tx.
// Only complete packets are offered to usb_tx, so txDataValid never drops mid-packet.
// A packet that cannot fit in the FIFO is discarded up to and including its last byte.
module usb_tx_packet_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk48,
  input  logic                     RST,
  input  logic [7:0]               inData,
  input  logic                     inValid,
  input  logic                     inLast,
  output logic                     inReady,
  output logic                     txReqSendPacket,
  input  logic                     txAcceptNewData,
  output logic                     txIsLastByte,
  output logic                     txDataValid,
  output logic [7:0]               txData,
  input  logic                     sending,
  output logic [$clog2(DEPTH):0]   pktPending,
  output logic                     dropErr
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  typedef logic [AddrW:0] ptr_t;
  localparam ptr_t PtrOne = ptr_t'(1);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StDrain} state_e;

  state_e     stateQ, stateD;
  ptr_t       wrPtrQ, rdPtrQ, cmtPtrQ;
  ptr_t       pendQ;
  logic       discardQ;
  logic       dropErrQ;
  logic [8:0] mem [DEPTH];

  logic [8:0] head;
  logic       full;
  logic       pop;
  logic       push;
  logic       store;
  logic       overflow;
  logic       incPend;
  logic       decPend;

  // Entry layout is {last, data}; pointers carry an extra wrap bit.
  assign head     = mem[rdPtrQ[AddrW-1:0]];
  assign full     = (wrPtrQ[AddrW] != rdPtrQ[AddrW]) &&
                    (wrPtrQ[AddrW-1:0] == rdPtrQ[AddrW-1:0]);
  assign pop      = (stateQ == StStream) && txAcceptNewData;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a byte.
  assign inReady  = !full || discardQ || pop;
  assign push     = inValid && inReady;
  assign store    = push && !discardQ;
  // Full with no complete packet stored: the packet in flight can never fit.
  assign overflow = full && (pendQ == '0) && !discardQ;
  assign incPend  = store && inLast;
  assign decPend  = pop && head[8];

  assign pktPending = pendQ;
  assign dropErr    = dropErrQ;

  // Byte storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk48) begin
    if (store) begin
      mem[wrPtrQ[AddrW-1:0]] <= {inLast, inData};
    end
  end

  // Pointers, packet count, discard mode and drop pulse.
  always_ff @(posedge clk48) begin
    if (RST) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      cmtPtrQ  <= '0;
      pendQ    <= '0;
      discardQ <= 1'b0;
      dropErrQ <= 1'b0;
    end else begin
      if (overflow) begin
        wrPtrQ <= cmtPtrQ;
      end else if (store) begin
        wrPtrQ <= wrPtrQ + PtrOne;
      end
      if (incPend) begin
        cmtPtrQ <= wrPtrQ + PtrOne;
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PtrOne;
      end
      if (overflow) begin
        discardQ <= 1'b1;
      end else if (push && discardQ && inLast) begin
        discardQ <= 1'b0;
      end
      dropErrQ <= overflow;
      if (incPend && !decPend) begin
        pendQ <= pendQ + PtrOne;
      end else if (decPend && !incPend) begin
        pendQ <= pendQ - PtrOne;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk48) begin
    if (RST) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next state and usb_tx-facing outputs.
  always_comb begin
    stateD          = stateQ;
    txReqSendPacket = 1'b0;
    txDataValid     = 1'b0;
    txIsLastByte    = 1'b0;
    txData          = 8'h00;
    case (stateQ)
      StIdle: begin
        if ((pendQ != '0) && !sending) begin
          stateD = StReq;
        end
      end
      StReq: begin
        txReqSendPacket = 1'b1;
        if (sending) begin
          stateD = StStream;
        end
      end
      StStream: begin
        txDataValid  = 1'b1;
        txData       = head[7:0];
        txIsLastByte = head[8];
        if (txAcceptNewData && head[8]) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (!sending) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_packet_buffer.sv
// Directed bench for usb_tx_packet_buffer: a per-cycle vector table for a single
// packet, then hand-written sequences for stalls, overflow, reset and full-FIFO traffic.
module tb_usb_tx_packet_buffer;

  localparam int unsigned DEPTH = 64;

  logic       clk48 = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] inData = 8'h00;
  logic       inValid = 1'b0;
  logic       inLast = 1'b0;
  logic       inReady;
  logic       txReqSendPacket;
  logic       txAcceptNewData = 1'b0;
  logic       txIsLastByte;
  logic       txDataValid;
  logic [7:0] txData;
  logic       sending = 1'b0;
  logic [6:0] pktPending;
  logic       dropErr;

  int nCompared = 0;
  int nFailed = 0;
  int dropSeen = 0;

  logic [8:0] expQ[$];
  logic [8:0] eMain;
  logic       lastBit;

  typedef struct packed {
    logic       inValid;
    logic [7:0] inData;
    logic       inLast;
    logic       acc;
    logic       snd;
    logic       expReq;
    logic       expDv;
    logic [7:0] expData;
    logic       expLast;
    logic [6:0] expPend;
    logic       expReady;
    logic       expDrop;
  } vec_t;

  vec_t vecs[13];

  usb_tx_packet_buffer #(.DEPTH(DEPTH)) dut (
    .clk48          (clk48),
    .RST            (RST),
    .inData         (inData),
    .inValid        (inValid),
    .inLast         (inLast),
    .inReady        (inReady),
    .txReqSendPacket(txReqSendPacket),
    .txAcceptNewData(txAcceptNewData),
    .txIsLastByte   (txIsLastByte),
    .txDataValid    (txDataValid),
    .txData         (txData),
    .sending        (sending),
    .pktPending     (pktPending),
    .dropErr        (dropErr)
  );

  always #5 clk48 = ~clk48;

  // Counts every cycle on which dropErr is seen high.
  always @(negedge clk48) begin
    if (dropErr === 1'b1) dropSeen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mkVec(input logic iv, input logic [7:0] d, input logic l,
                                 input logic a, input logic s, input logic eReq,
                                 input logic eDv, input logic [7:0] eData, input logic eLast,
                                 input logic [6:0] ePend, input logic eRdy, input logic eDrop);
    vec_t v;
    v.inValid = iv;   v.inData = d;      v.inLast = l;     v.acc = a;       v.snd = s;
    v.expReq = eReq;  v.expDv = eDv;     v.expData = eData; v.expLast = eLast;
    v.expPend = ePend; v.expReady = eRdy; v.expDrop = eDrop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nFailed++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk48);
    #1;
  endtask

  task automatic chkIdleOutputs(input string tag);
    @(negedge clk48);
    chk({tag, " txReqSendPacket"}, 32'(txReqSendPacket), 32'(0));
    chk({tag, " txDataValid"}, 32'(txDataValid), 32'(0));
    chk({tag, " txIsLastByte"}, 32'(txIsLastByte), 32'(0));
    chk({tag, " txData"}, 32'(txData), 32'(0));
    chk({tag, " dropErr"}, 32'(dropErr), 32'(0));
    chk({tag, " inReady"}, 32'(inReady), 32'(1));
    chk({tag, " pktPending"}, 32'(pktPending), 32'(0));
  endtask

  task automatic pushByte(input logic [7:0] d, input logic l);
    inValid = 1'b1;
    inData  = d;
    inLast  = l;
    @(negedge clk48);
    chk("inReady on push", 32'(inReady), 32'(1));
    nextCycle();
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Plays usb_tx for every packet queued in expQ, checking bytes in order.
  task automatic drainAll();
    logic [8:0] e;
    int guard;
    bit done;
    while (expQ.size() > 0) begin
      sending = 1'b0;
      txAcceptNewData = 1'b0;
      guard = 0;
      @(negedge clk48);
      while (txReqSendPacket !== 1'b1 && guard < 20) begin
        nextCycle();
        @(negedge clk48);
        guard++;
      end
      chk("req before stream", 32'(txReqSendPacket), 32'(1));
      if (txReqSendPacket !== 1'b1) begin
        expQ.delete();
        return;
      end
      nextCycle();
      sending = 1'b1;
      nextCycle();
      txAcceptNewData = 1'b1;
      done = 1'b0;
      while (!done && expQ.size() > 0) begin
        e = expQ.pop_front();
        @(negedge clk48);
        chk("stream valid", 32'(txDataValid), 32'(1));
        chk("stream data", 32'(txData), 32'(e[7:0]));
        chk("stream last", 32'(txIsLastByte), 32'(e[8]));
        nextCycle();
        done = e[8];
      end
      txAcceptNewData = 1'b0;
      @(negedge clk48);
      chk("drain valid low", 32'(txDataValid), 32'(0));
      nextCycle();
      sending = 1'b0;
      nextCycle();
    end
  endtask

  initial begin
    // One packet {C3, 01, 02(last)}, cycle by cycle.
    //              inV  data  last acc snd | req dv data  last pend rdy drop
    vecs[0]  = mkVec(1, 8'hC3, 0, 0, 0,      0,  0, 8'h00, 0,  0,   1,  0);
    vecs[1]  = mkVec(1, 8'h01, 0, 0, 0,      0,  0, 8'h00, 0,  0,   1,  0);
    vecs[2]  = mkVec(1, 8'h02, 1, 0, 0,      0,  0, 8'h00, 0,  0,   1,  0);
    vecs[3]  = mkVec(0, 8'h00, 0, 0, 0,      0,  0, 8'h00, 0,  1,   1,  0);
    vecs[4]  = mkVec(0, 8'h00, 0, 0, 0,      1,  0, 8'h00, 0,  1,   1,  0);
    vecs[5]  = mkVec(0, 8'h00, 0, 0, 1,      1,  0, 8'h00, 0,  1,   1,  0);
    vecs[6]  = mkVec(0, 8'h00, 0, 0, 1,      0,  1, 8'hC3, 0,  1,   1,  0);
    vecs[7]  = mkVec(0, 8'h00, 0, 1, 1,      0,  1, 8'hC3, 0,  1,   1,  0);
    vecs[8]  = mkVec(0, 8'h00, 0, 1, 1,      0,  1, 8'h01, 0,  1,   1,  0);
    vecs[9]  = mkVec(0, 8'h00, 0, 1, 1,      0,  1, 8'h02, 1,  1,   1,  0);
    vecs[10] = mkVec(0, 8'h00, 0, 0, 1,      0,  0, 8'h00, 0,  0,   1,  0);
    vecs[11] = mkVec(0, 8'h00, 0, 0, 0,      0,  0, 8'h00, 0,  0,   1,  0);
    vecs[12] = mkVec(0, 8'h00, 0, 0, 0,      0,  0, 8'h00, 0,  0,   1,  0);

    // Reset
    repeat (3) @(posedge clk48);
    #1;
    RST = 1'b0;
    chkIdleOutputs("reset");
    nextCycle();

    // Table-driven single packet
    for (int i = 0; i < 13; i++) begin
      inValid = vecs[i].inValid;
      inData = vecs[i].inData;
      inLast = vecs[i].inLast;
      txAcceptNewData = vecs[i].acc;
      sending = vecs[i].snd;
      @(negedge clk48);
      chk($sformatf("vec[%0d] {req,dv,data,last,pend,rdy,drop}", i),
          32'({txReqSendPacket, txDataValid, txData, txIsLastByte, pktPending, inReady, dropErr}),
          32'({vecs[i].expReq, vecs[i].expDv, vecs[i].expData, vecs[i].expLast,
               vecs[i].expPend, vecs[i].expReady, vecs[i].expDrop}));
      nextCycle();
    end
    inValid = 1'b0; inLast = 1'b0; txAcceptNewData = 1'b0; sending = 1'b0;

    // Two packets back to back, 5-cycle stall, second REQ only after sending falls
    pushByte(8'hA1, 1'b0);
    pushByte(8'hA2, 1'b1);
    pushByte(8'hB1, 1'b1);
    sending = 1'b1;
    @(negedge clk48);
    chk("two packets pending", 32'(pktPending), 32'(2));
    chk("req for first packet", 32'(txReqSendPacket), 32'(1));
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk48);
      chk("stall data steady", 32'(txData), 32'(8'hA1));
      chk("stall valid", 32'(txDataValid), 32'(1));
      nextCycle();
    end
    txAcceptNewData = 1'b1;
    @(negedge clk48);
    chk("first byte after stall", 32'(txData), 32'(8'hA1));
    nextCycle();
    @(negedge clk48);
    chk("second byte", 32'(txData), 32'(8'hA2));
    chk("second byte last", 32'(txIsLastByte), 32'(1));
    nextCycle();
    txAcceptNewData = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk48);
      chk("no req while sending", 32'(txReqSendPacket), 32'(0));
      chk("pending during drain", 32'(pktPending), 32'(1));
      nextCycle();
    end
    sending = 1'b0;
    @(negedge clk48);
    chk("no req in drain", 32'(txReqSendPacket), 32'(0));
    nextCycle();
    @(negedge clk48);
    chk("no req first idle cycle", 32'(txReqSendPacket), 32'(0));
    nextCycle();
    @(negedge clk48);
    chk("second req", 32'(txReqSendPacket), 32'(1));
    nextCycle();
    expQ.push_back({1'b1, 8'hB1});
    drainAll();

    // Last byte written on the cycle the previous last byte is popped
    pushByte(8'h10, 1'b0);
    pushByte(8'h11, 1'b1);
    nextCycle();
    sending = 1'b1;
    nextCycle();
    txAcceptNewData = 1'b1;
    @(negedge clk48);
    chk("pkt 10 first", 32'(txData), 32'(8'h10));
    nextCycle();
    inValid = 1'b1; inData = 8'h20; inLast = 1'b1;
    @(negedge clk48);
    chk("pkt 10 last data", 32'(txData), 32'(8'h11));
    chk("pkt 10 last flag", 32'(txIsLastByte), 32'(1));
    chk("pending before overlap", 32'(pktPending), 32'(1));
    nextCycle();
    inValid = 1'b0; inLast = 1'b0; txAcceptNewData = 1'b0;
    @(negedge clk48);
    chk("pending after push+pop last", 32'(pktPending), 32'(1));
    chk("drain after last pop", 32'(txDataValid), 32'(0));
    nextCycle();
    expQ.push_back({1'b1, 8'h20});
    drainAll();

    // Reset in the middle of STREAM after 2 of 5 bytes
    for (int i = 0; i < 5; i++) pushByte(8'(8'h31 + i), (i == 4));
    nextCycle();
    sending = 1'b1;
    nextCycle();
    txAcceptNewData = 1'b1;
    @(negedge clk48);
    chk("mid-stream byte 0", 32'(txData), 32'(8'h31));
    nextCycle();
    nextCycle();
    RST = 1'b1;
    nextCycle();
    RST = 1'b0; txAcceptNewData = 1'b0; sending = 1'b0;
    chkIdleOutputs("mid-stream reset");
    repeat (3) begin
      nextCycle();
      @(negedge clk48);
      chk("no req after reset", 32'(txReqSendPacket), 32'(0));
    end
    nextCycle();
    pushByte(8'h44, 1'b1);
    expQ.push_back({1'b1, 8'h44});
    drainAll();

    // Oversize packet: 64 bytes without last
    for (int i = 0; i < 64; i++) pushByte(8'(i), 1'b0);
    inValid = 1'b1; inData = 8'hEE; inLast = 1'b0;
    @(negedge clk48);
    chk("full blocks input", 32'(inReady), 32'(0));
    chk("dropErr before overflow", 32'(dropErr), 32'(0));
    nextCycle();
    @(negedge clk48);
    chk("dropErr pulse", 32'(dropErr), 32'(1));
    chk("inReady in discard", 32'(inReady), 32'(1));
    nextCycle();
    inData = 8'hEF;
    @(negedge clk48);
    chk("dropErr single cycle", 32'(dropErr), 32'(0));
    nextCycle();
    inData = 8'hF0; inLast = 1'b1;
    @(negedge clk48);
    chk("inReady for discard last", 32'(inReady), 32'(1));
    nextCycle();
    inValid = 1'b0; inLast = 1'b0;
    @(negedge clk48);
    chk("pending after discard", 32'(pktPending), 32'(0));
    chk("inReady after discard", 32'(inReady), 32'(1));
    repeat (3) begin
      nextCycle();
      @(negedge clk48);
      chk("no req after drop", 32'(txReqSendPacket), 32'(0));
    end
    nextCycle();
    pushByte(8'h5A, 1'b1);
    expQ.push_back({1'b1, 8'h5A});
    drainAll();

    // Full FIFO of 4-byte packets, then push and pop together
    for (int i = 0; i < 64; i++) begin
      lastBit = ((i % 4) == 3);
      pushByte(8'(i), lastBit);
      expQ.push_back({lastBit, 8'(i)});
    end
    @(negedge clk48);
    chk("full inReady", 32'(inReady), 32'(0));
    chk("full pending", 32'(pktPending), 32'(16));
    nextCycle();
    sending = 1'b1;
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      inValid = 1'b1; inData = 8'(8'h40 + k); inLast = (k == 3); txAcceptNewData = 1'b1;
      eMain = expQ.pop_front();
      @(negedge clk48);
      chk("full push+pop inReady", 32'(inReady), 32'(1));
      chk("full push+pop data", 32'(txData), 32'(eMain[7:0]));
      expQ.push_back({inLast, inData});
      nextCycle();
    end
    inValid = 1'b0; inLast = 1'b0; txAcceptNewData = 1'b0;
    @(negedge clk48);
    chk("pending after concurrent", 32'(pktPending), 32'(16));
    chk("still full", 32'(inReady), 32'(0));
    nextCycle();
    drainAll();

    chk("dropErr pulse count", 32'(dropSeen), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
